// File: rtl/enum_type.sv
// enum_type: shared types, message templates and byte helpers for the UART status reporter
package enum_type;
  typedef enum logic [2:0] {IDLE, SNAP, CONVERT, LOAD, STROBE, WAIT_BUSY, WAIT_DONE} reporter_state_type;
  typedef enum logic [1:0] {MSG_GO, MSG_TIME, MSG_OVER} msg_type;
  localparam int GO_LEN = 4;
  localparam int TIME_LEN = 7;
  localparam int OVER_LEN = 19;
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;
  localparam logic [8*GO_LEN-1:0] GO_T = {"GO", CR, LF};
  localparam logic [8*TIME_LEN-1:0] TIME_T = {"T=000", CR, LF};
  localparam logic [8*OVER_LEN-1:0] OVER_T = {"OVER S=0000 T=000", CR, LF};

  function automatic logic [7:0] dgt(logic [3:0] n);
    return {4'h0, n} + (n < 4'd10 ? 8'h30 : 8'h37);
  endfunction

  function automatic logic [4:0] msg_len(msg_type m);
    return m == MSG_GO ? 5'(GO_LEN) : m == MSG_TIME ? 5'(TIME_LEN) : 5'(OVER_LEN);
  endfunction

  // digit positions are patched over the fixed template text
  function automatic logic [7:0] msg_byte(msg_type m, logic [4:0] i, logic [15:0] s, logic [11:0] d);
    int k;
    k = int'(i);
    if (m == MSG_GO) return GO_T[8*(GO_LEN-1-k) +: 8];
    if (m == MSG_TIME) return k >= 2 && k <= 4 ? dgt(d[4*(4-k) +: 4]) : TIME_T[8*(TIME_LEN-1-k) +: 8];
    return k >= 7 && k <= 10 ? dgt(s[4*(10-k) +: 4]) :
           k >= 14 && k <= 16 ? dgt(d[4*(16-k) +: 4]) : OVER_T[8*(OVER_LEN-1-k) +: 8];
  endfunction
endpackage

// File: rtl/game_uart_reporter_if.sv
// game_uart_reporter_if: byte port between the reporter and the UART transmitter
interface game_uart_reporter_if;
  logic transmit;
  logic [7:0] tx_byte;
  logic is_transmitting;
  modport master(output transmit, tx_byte, input is_transmitting);
  modport slave(input transmit, tx_byte, output is_transmitting);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble to three BCD digits, W cycles, saturating at 999
module bin2bcd_seq #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         go,
  input  logic [W-1:0] bin,
  output logic [11:0]  bcd,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] sh;
  logic [11:0] acc, adj;
  logic [CW-1:0] cnt;
  logic sat;
  // add 3 to every digit of 5 or more before it is shifted
  always_comb begin
    adj = acc;
    for (int i = 0; i < 3; i++) adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  // load on go, then shift one input bit per cycle into the digit accumulator
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (go) begin
      sh <= bin;
      acc <= '0;
      cnt <= CW'(W);
      sat <= 32'(bin) > 999;
    end else if (cnt != '0) begin
      sh <= sh << 1;
      acc <= {adj[10:0], sh[W-1]};
      cnt <= cnt - CW'(1);
    end
  end
  assign done = cnt == CW'(1);
  assign bcd = sat ? 12'h999 : acc;
endmodule

// File: rtl/game_uart_reporter.sv
// game_uart_reporter: formats game status lines and streams them into the UART transmitter
module game_uart_reporter
  import enum_type::*;
#(
  parameter int CNT_W = 10,
  parameter bit REPORT_TIME = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             over,
  input  logic [15:0]      score,
  input  logic [CNT_W-1:0] count_down,
  output logic             busy,
  game_uart_reporter_if.master uart
);
  reporter_state_type state, state_nx;
  msg_type msg, sel;
  logic start_q, over_q, ev_go, ev_over, ev_time, f_go, f_over, f_time, snap, done, last;
  logic [CNT_W-1:0] cd_q;
  logic [4:0] idx;
  logic [1:0] gcnt;
  logic [15:0] score_s;
  logic [11:0] bcd;
  logic [7:0] tx_q;

  assign ev_go = start & ~start_q;
  assign ev_over = over & ~over_q;
  assign ev_time = (count_down != cd_q) & start & ~over & REPORT_TIME;
  assign sel = f_over ? MSG_OVER : f_go ? MSG_GO : MSG_TIME;
  assign snap = state == SNAP;
  assign last = idx == msg_len(msg) - 5'd1;

  bin2bcd_seq #(.W(CNT_W)) u_b2b (
    .clk(clk), .reset_n(reset_n), .go(snap), .bin(count_down), .bcd(bcd), .done(done)
  );

  // state register
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_nx;

  // next-state: one byte per LOAD..WAIT_DONE round; guard counter bounds the wait for busy
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (f_go | f_over | f_time) state_nx = SNAP;
      SNAP:      state_nx = sel == MSG_GO ? LOAD : CONVERT;
      CONVERT:   if (done) state_nx = LOAD;
      LOAD:      state_nx = STROBE;
      STROBE:    if (!uart.is_transmitting) state_nx = WAIT_BUSY;
      WAIT_BUSY: if (uart.is_transmitting || gcnt == 2'd3) state_nx = WAIT_DONE;
      WAIT_DONE: if (!uart.is_transmitting) state_nx = last ? IDLE : LOAD;
      default:   state_nx = IDLE;
    endcase
  end

  // outputs: single strobe once the UART is free, byte held from LOAD onwards
  always_comb begin
    uart.transmit = state == STROBE && !uart.is_transmitting;
    uart.tx_byte = tx_q;
    busy = state != IDLE || f_go || f_over || f_time;
  end

  // edge detect, sticky event flags, message snapshot and byte sequencing
  always_ff @(posedge clk) begin
    start_q <= start;
    over_q <= over;
    cd_q <= count_down;
    if (!reset_n) begin
      f_go <= 1'b0;
      f_over <= 1'b0;
      f_time <= 1'b0;
      msg <= MSG_GO;
      score_s <= '0;
      idx <= '0;
      gcnt <= '0;
      tx_q <= '0;
    end else begin
      f_over <= (f_over & ~(snap && sel == MSG_OVER)) | ev_over;
      f_go <= (f_go & ~(snap && sel == MSG_GO)) | ev_go;
      f_time <= (f_time & ~(snap && sel != MSG_GO)) | ev_time;
      if (snap) begin
        msg <= sel;
        score_s <= score;
        idx <= '0;
      end
      if (state == LOAD) tx_q <= msg_byte(msg, idx, score_s, bcd);
      if (state == WAIT_DONE && !uart.is_transmitting) idx <= idx + 5'd1;
      gcnt <= state == WAIT_BUSY ? gcnt + 2'd1 : 2'd0;
    end
  end
endmodule

// File: tb/tb_game_uart_reporter.sv
// tb_game_uart_reporter: directed checks of the status-line reporter against a simple UART model
module tb_game_uart_reporter;
  logic clk, reset_n, start, over, busy, hold;
  logic [15:0] score;
  logic [9:0] count_down;
  logic [7:0] bytes[$];
  int cycs[$];
  int cyc = 0, nstb = 0, seen = 0, rem = 0, base = 0, k = 0, n_tests = 0, n_fail = 0;

  game_uart_reporter_if tx();

  game_uart_reporter #(.CNT_W(10), .REPORT_TIME(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .over(over), .score(score),
    .count_down(count_down), .busy(busy), .uart(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // record every strobe together with its cycle number
  always @(negedge clk) begin
    if (tx.transmit) begin
      bytes.push_back(tx.tx_byte);
      cycs.push_back(cyc);
      nstb++;
    end
  end

  // UART model: busy for three cycles after each strobe, or forced busy by hold
  always @(posedge clk) begin
    #1;
    if (nstb != seen) begin
      seen = nstb;
      rem = 3;
    end else if (rem > 0) rem--;
    tx.is_transmitting = hold || rem > 0;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && bytes.size() < base + n; i++) tick;
    chk({tag, "_count"}, bytes.size() - base, n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_line(input string tag, input string exp, input int at);
    for (int i = 0; i < exp.len(); i++) chk($sformatf("%s[%0d]", tag, i), bytes[at+i], exp[i]);
    chk({tag, "_cr"}, bytes[at+exp.len()], 8'h0d);
    chk({tag, "_lf"}, bytes[at+exp.len()+1], 8'h0a);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk = 0; reset_n = 0; start = 0; over = 0; hold = 0;
    score = 16'h0123; count_down = 10'd42;
    tx.is_transmitting = 0;
    repeat (3) tick;
    chk("rst_transmit", tx.transmit, 0);
    chk("rst_tx_byte", tx.tx_byte, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1;
    repeat (3) tick;
    chk("release_quiet", bytes.size(), 0);

    base = bytes.size(); k = cyc; start = 1;
    wait_bytes("go", 4, 200);
    check_line("go", "GO", base);
    if (cycs.size() > base) chk("go_latency", cycs[base] - k, 4);
    wait_idle("go", 200);

    base = bytes.size(); k = cyc; over = 1;
    wait_bytes("over", 19, 1000);
    check_line("over", "OVER S=0123 T=042", base);
    if (cycs.size() > base) chk("over_latency", cycs[base] - k, 14);
    wait_idle("over", 200);
    repeat (50) tick;
    chk("over_no_extra", bytes.size() - base, 19);

    count_down = 10'd1023; score = 16'hA0F9;
    tick;
    start = 0; over = 0;
    repeat (3) tick;
    base = bytes.size(); over = 1;
    wait_bytes("sat", 19, 1000);
    check_line("sat", "OVER S=A0F9 T=999", base);
    wait_idle("sat", 200);

    over = 0; score = 16'h0456; count_down = 10'd5;
    repeat (3) tick;
    base = bytes.size(); start = 1;
    repeat (2) tick; count_down = 10'd6;
    repeat (2) tick; count_down = 10'd7;
    repeat (2) tick; count_down = 10'd8;
    repeat (2) tick; over = 1;
    wait_bytes("prio", 23, 3000);
    check_line("prio_go", "GO", base);
    check_line("prio_over", "OVER S=0456 T=008", base + 4);
    wait_idle("prio", 200);
    repeat (100) tick;
    chk("prio_no_time", bytes.size() - base, 23);

    start = 0; over = 0;
    repeat (3) tick;
    hold = 1;
    repeat (2) tick;
    base = bytes.size(); start = 1;
    repeat (500) tick;
    chk("bp_no_strobe", bytes.size() - base, 0);
    hold = 0; k = cyc;
    wait_bytes("bp", 4, 500);
    if (cycs.size() > base) chk("bp_release", cycs[base] - k, 1);
    check_line("bp", "GO", base);
    wait_idle("bp", 200);

    start = 0; over = 0;
    repeat (3) tick;
    base = bytes.size(); over = 1;
    wait_bytes("rmid", 5, 500);
    reset_n = 0;
    tick;
    chk("rmid_transmit", tx.transmit, 0);
    chk("rmid_busy", busy, 0);
    tick;
    reset_n = 1;
    repeat (100) tick;
    chk("rmid_no_bytes", bytes.size() - base, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
